// File: rtl/cnt_pkg.sv
// Shared types and parameter legality checks for the step/mode counter family.
package cnt_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP   = 2'd0,
        CNT_SAT    = 2'd1,
        CNT_BOUNCE = 2'd2,
        CNT_RSVD   = 2'd3
    } cnt_mode_t;

    // True when the bounds and step describe a usable counter.
    function automatic bit cnt_params_legal(input int max, input int min, input int step);
        return (min >= 0) && (min < max) && (step >= 1) && (step <= max - min);
    endfunction

endpackage

// File: rtl/cnt_step_calc.sv
// Combinational next-count, terminal-count and bounce-toggle computation.
// Bounce handling exists only when CNT_STEP_MODE_BOUNCE_EN is defined.
module cnt_step_calc
    import cnt_pkg::*;
#(
    parameter int          MAX  = 15,
    parameter int          MIN  = 0,
    parameter int          STEP = 1,
    parameter int          R    = 16,
    parameter int unsigned W    = 4
) (
    input  logic [W-1:0] cnt,
    input  logic         dir,
    input  cnt_mode_t    mode,
    output logic [W-1:0] nxt_c,
    output logic         tc_c
`ifdef CNT_STEP_MODE_BOUNCE_EN
    ,
    output logic         toggle_c
`endif
);

    localparam int unsigned UW = W + 2;
    localparam logic signed [UW-1:0] MAX_S  = UW'(MAX);
    localparam logic signed [UW-1:0] MIN_S  = UW'(MIN);
    localparam logic signed [UW-1:0] STEP_S = UW'(STEP);
    localparam logic signed [UW-1:0] R_S    = UW'(R);

    logic signed [UW-1:0] u;
    logic                 over;
    logic                 under;
    logic [W-1:0]         clamped;
    logic [W-1:0]         wrapped;

    // STEP < R, so a single add/subtract of R is enough to wrap.
    always_comb begin
        u       = dir ? ($signed({2'b00, cnt}) - STEP_S) : ($signed({2'b00, cnt}) + STEP_S);
        over    = (u > MAX_S);
        under   = (u < MIN_S);
        clamped = over ? W'(MAX) : (under ? W'(MIN) : W'(u));
        wrapped = over ? W'(u - R_S) : (under ? W'(u + R_S) : W'(u));
    end

    always_comb begin
        nxt_c = wrapped;
        tc_c  = over | under;
`ifdef CNT_STEP_MODE_BOUNCE_EN
        toggle_c = 1'b0;
`endif
        if (mode == CNT_SAT) begin
            nxt_c = clamped;
        end
`ifdef CNT_STEP_MODE_BOUNCE_EN
        // Bounce turns around on reaching a bound, not only on overshooting it.
        if (mode == CNT_BOUNCE) begin
            nxt_c    = clamped;
            toggle_c = dir ? (u <= MIN_S) : (u >= MAX_S);
            tc_c     = toggle_c;
        end
`endif
    end

endmodule

// File: rtl/cnt_step_mode.sv
// Up/down step counter with wrap/saturate/bounce modes, parallel load and tc pulse.
// Define CNT_STEP_MODE_BOUNCE_EN to build BOUNCE mode; otherwise mode 2 wraps.
module cnt_step_mode
    import cnt_pkg::*;
#(
    parameter  int          MAX  = 15,
    parameter  int          MIN  = 0,
    parameter  int          STEP = 1,
    localparam int unsigned W    = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         sys_rst,
    input  logic         enable,
    input  logic         U_D,
    input  cnt_mode_t    mode,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         dir,
    output logic         tc
);

    localparam int R = MAX - MIN + 1;

    if (!cnt_params_legal(MAX, MIN, STEP)) begin : g_param_check
        $error("cnt_step_mode: illegal MAX/MIN/STEP combination");
    end

    logic [W-1:0] step_nxt_c;
    logic         step_tc_c;
`ifdef CNT_STEP_MODE_BOUNCE_EN
    logic         step_toggle_c;
`endif
    logic [W-1:0] load_clamped_c;
    logic [W-1:0] cnt_d;
    logic         dir_d;
    logic         tc_d;

    cnt_step_calc #(
        .MAX  (MAX),
        .MIN  (MIN),
        .STEP (STEP),
        .R    (R),
        .W    (W)
    ) u_calc (
        .cnt      (cnt),
        .dir      (dir),
        .mode     (mode),
        .nxt_c    (step_nxt_c),
        .tc_c     (step_tc_c)
`ifdef CNT_STEP_MODE_BOUNCE_EN
        ,
        .toggle_c (step_toggle_c)
`endif
    );

    // Load value clamp; compared as int so MIN=0 or MAX=2**W-1 stay well-formed.
    always_comb begin
        load_clamped_c = load_val;
        if (int'(load_val) > MAX) begin
            load_clamped_c = W'(MAX);
        end else if (int'(load_val) < MIN) begin
            load_clamped_c = W'(MIN);
        end
    end

    // Priority: load, then enable, then hold. Non-bounce modes track U_D every cycle.
    always_comb begin
        cnt_d = cnt;
        dir_d = U_D;
        tc_d  = 1'b0;
`ifdef CNT_STEP_MODE_BOUNCE_EN
        if (mode == CNT_BOUNCE) begin
            dir_d = dir;
        end
`endif
        if (load) begin
            cnt_d = load_clamped_c;
            dir_d = U_D;
        end else if (enable) begin
            cnt_d = step_nxt_c;
            tc_d  = step_tc_c;
`ifdef CNT_STEP_MODE_BOUNCE_EN
            if (mode == CNT_BOUNCE) begin
                dir_d = dir ^ step_toggle_c;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            cnt <= W'(MIN);
            dir <= 1'b0;
            tc  <= 1'b0;
        end else begin
            cnt <= cnt_d;
            dir <= dir_d;
            tc  <= tc_d;
        end
    end

endmodule

// File: tb/tb_cnt_step_mode.sv
// Bench for cnt_step_mode at MAX=9, MIN=2, STEP=3: directed table, bounce run, random vs model.
module tb_cnt_step_mode;
    import cnt_pkg::*;

    localparam int MAX  = 9;
    localparam int MIN  = 2;
    localparam int STEP = 3;
    localparam int R    = MAX - MIN + 1;
`ifdef CNT_STEP_MODE_BOUNCE_EN
    localparam bit BNC_EN = 1'b1;
`else
    localparam bit BNC_EN = 1'b0;
`endif

    typedef struct {
        bit        rst;
        bit        ld;
        bit        en;
        bit        ud;
        cnt_mode_t md;
        int        lv;
        int        e_cnt;
        bit        e_dir;
        bit        e_tc;
    } vec_t;

    logic       clk;
    logic       sys_rst;
    logic       enable;
    logic       U_D;
    cnt_mode_t  mode;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] cnt;
    logic       dir;
    logic       tc;

    int checks   = 0;
    int failures = 0;

    int m_cnt = MIN;
    bit m_dir = 1'b0;
    bit m_tc  = 1'b0;

    cnt_step_mode #(.MAX(MAX), .MIN(MIN), .STEP(STEP)) dut (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .enable   (enable),
        .U_D      (U_D),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .dir      (dir),
        .tc       (tc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t v(bit r, bit ld, bit en, bit ud, cnt_mode_t md, int lv,
                               int c, bit d, bit t);
        vec_t x;
        x.rst = r; x.ld = ld; x.en = en; x.ud = ud; x.md = md; x.lv = lv;
        x.e_cnt = c; x.e_dir = d; x.e_tc = t;
        return x;
    endfunction

    function automatic int clampi(int x);
        return (x > MAX) ? MAX : ((x < MIN) ? MIN : x);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference behaviour of one rising edge, written from the counter's rules.
    task automatic model_edge(input bit r, input bit ld, input bit en, input bit ud,
                              input cnt_mode_t md, input int lv);
        int u;
        bit bnc;
        bnc = BNC_EN && (md == CNT_BOUNCE);
        if (r) begin
            m_cnt = MIN; m_dir = 1'b0; m_tc = 1'b0;
        end else if (ld) begin
            m_cnt = clampi(lv); m_dir = ud; m_tc = 1'b0;
        end else begin
            m_tc = 1'b0;
            if (en) begin
                u = m_dir ? (m_cnt - STEP) : (m_cnt + STEP);
                if (bnc) begin
                    m_cnt = clampi(u);
                    if ((!m_dir && u >= MAX) || (m_dir && u <= MIN)) begin
                        m_dir = !m_dir;
                        m_tc  = 1'b1;
                    end
                end else begin
                    m_tc  = (u > MAX) || (u < MIN);
                    m_cnt = (md == CNT_SAT) ? clampi(u) : MIN + ((((u - MIN) % R) + R) % R);
                end
            end
            if (!bnc) m_dir = ud;
        end
    endtask

    task automatic drive(input bit r, input bit ld, input bit en, input bit ud,
                         input cnt_mode_t md, input int lv);
        sys_rst  = r;
        load     = ld;
        enable   = en;
        U_D      = ud;
        mode     = md;
        load_val = 4'(lv);
        @(posedge clk);
        model_edge(r, ld, en, ud, md, lv);
        #1;
    endtask

    vec_t tbl[$];
    int   b_cnt[6];
    bit   b_dir[6];
    bit   b_tc[6];
    bit   b_ud[6];
    bit   b_en[6];

    initial begin
        sys_rst = 1'b1; load = 1'b0; enable = 1'b0; U_D = 1'b0;
        mode = CNT_WRAP; load_val = 4'd0;

        //             rst ld en ud mode        lv  cnt dir tc
        tbl.push_back(v(1, 0, 0, 0, CNT_WRAP,    0,  2, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, CNT_WRAP,    0,  5, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, CNT_WRAP,    0,  8, 0, 0));
        tbl.push_back(v(1, 0, 1, 0, CNT_WRAP,    0,  2, 0, 0));
        tbl.push_back(v(1, 0, 1, 1, CNT_WRAP,    0,  2, 0, 0));
        tbl.push_back(v(1, 1, 1, 0, CNT_WRAP,    7,  2, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, CNT_WRAP,    0,  5, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, CNT_WRAP,    8,  8, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, CNT_WRAP,    0,  3, 0, 1));
        tbl.push_back(v(0, 0, 1, 0, CNT_WRAP,    0,  6, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, CNT_WRAP,    3,  3, 1, 0));
        tbl.push_back(v(0, 0, 1, 1, CNT_WRAP,    0,  8, 1, 1));
        tbl.push_back(v(0, 1, 0, 0, CNT_SAT,     8,  8, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, CNT_SAT,     0,  9, 0, 1));
        tbl.push_back(v(0, 0, 1, 0, CNT_SAT,     0,  9, 0, 1));
        tbl.push_back(v(0, 1, 0, 1, CNT_SAT,     4,  4, 1, 0));
        tbl.push_back(v(0, 0, 1, 1, CNT_SAT,     0,  2, 1, 1));
        tbl.push_back(v(0, 0, 1, 1, CNT_SAT,     0,  2, 1, 1));
        tbl.push_back(v(0, 1, 0, 0, CNT_WRAP,   12,  9, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, CNT_WRAP,    0,  2, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, CNT_WRAP,    5,  5, 0, 0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(v(0, 0, 0, 0, CNT_WRAP, 0, 5, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, CNT_WRAP,    0,  8, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, CNT_WRAP,    0,  3, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, CNT_WRAP,    0,  3, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, CNT_WRAP,    0,  6, 1, 0));
        tbl.push_back(v(0, 0, 1, 1, CNT_WRAP,    0,  3, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, CNT_WRAP,    0,  3, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, CNT_WRAP,    0,  6, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, CNT_RSVD,    8,  8, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, CNT_RSVD,    0,  3, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, CNT_WRAP,    8,  8, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, CNT_SAT,     0,  9, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].ld, tbl[i].en, tbl[i].ud, tbl[i].md, tbl[i].lv);
            chk($sformatf("vec%0d cnt", i), int'(cnt), tbl[i].e_cnt);
            chk($sformatf("vec%0d dir", i), int'(dir), int'(tbl[i].e_dir));
            chk($sformatf("vec%0d tc", i),  int'(tc),  int'(tbl[i].e_tc));
        end

        // Mode 2 run from 6 with U_D toggling, then one hold cycle.
        b_ud = '{1, 0, 1, 0, 1, 1};
        b_en = '{1, 1, 1, 1, 1, 0};
`ifdef CNT_STEP_MODE_BOUNCE_EN
        b_cnt = '{9, 6, 3, 2, 5, 5};
        b_dir = '{1, 1, 1, 0, 0, 0};
        b_tc  = '{1, 0, 0, 1, 0, 0};
`else
        b_cnt = '{9, 6, 9, 6, 9, 9};
        b_dir = '{1, 0, 1, 0, 1, 1};
        b_tc  = '{0, 0, 0, 0, 0, 0};
`endif
        drive(0, 1, 0, 0, CNT_BOUNCE, 6);
        chk("bnc load cnt", int'(cnt), 6);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, b_en[i], b_ud[i], CNT_BOUNCE, 0);
            chk($sformatf("bnc%0d cnt", i), int'(cnt), b_cnt[i]);
            chk($sformatf("bnc%0d dir", i), int'(dir), int'(b_dir[i]));
            chk($sformatf("bnc%0d tc", i),  int'(tc),  int'(b_tc[i]));
        end

        // Random traffic against the reference model; mode changes occasionally.
        begin
            cnt_mode_t rmd;
            rmd = CNT_WRAP;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 15) == 0) rmd = cnt_mode_t'($urandom_range(0, 3));
                drive($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      rmd, int'($urandom_range(0, 15)));
                chk($sformatf("rnd%0d cnt", i), int'(cnt), m_cnt);
                chk($sformatf("rnd%0d dir", i), int'(dir), int'(m_dir));
                chk($sformatf("rnd%0d tc", i),  int'(tc),  int'(m_tc));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
